// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tpu_pkg
// Purpose : Shared definitions for the systolic-array subsystem: controller
//           state encoding, default array size, PE datapath widths and a
//           helper that sizes the controller's phase counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int c_n_default = 2;   // default array dimension
  localparam int c_pe_data_w = 8;   // PE operand width
  localparam int c_pe_acc_w  = 32;  // PE accumulator width

  typedef logic [c_pe_data_w-1:0] pe_data_t;
  typedef logic [c_pe_acc_w-1:0]  pe_acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of a counter that must reach both N (weight phase) and
  // (2^row_w - 1) + pipe_lat (longest run phase) without wrapping.
  function automatic int cnt_width(input int row_w, input int pipe_lat, input int n);
    int max_cnt;
    max_cnt = (1 << row_w) - 1 + pipe_lat;
    if (n > max_cnt) max_cnt = n;
    return $clog2(max_cnt + 1);
  endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/systolic_array_controller.sv
`default_nettype none
// ============================================================================
// Module  : systolic_array_controller
// Purpose : Sequences an N x N weight-stationary PE array: preloads N weight
//           rows, streams M activation rows keeping the array advancing until
//           it drains, and writes results back as they emerge.
// Ports   : clk, reset (async, active-high)
//           start, num_rows      - command pulse and row count M (IDLE only)
//           hold                 - stall, freezes sequencing and strobes
//           wmem_rd_en/wmem_addr - weight memory read
//           load_weight          - one-hot per-row weight load
//           amem_rd_en/amem_addr - activation memory read
//           valid                - array advance enable
//           res_wr_en/res_addr   - result memory write
//           busy, done           - status
// Revision: 1.0 - initial release
// ============================================================================
module systolic_array_controller
  import tpu_pkg::*;
#(
  parameter int N        = c_n_default,
  parameter int ROW_W    = 8,
  parameter int PIPE_LAT = 2 * N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROW_W-1:0]     num_rows,
  input  logic                 hold,
  output logic                 wmem_rd_en,
  output logic [$clog2(N)-1:0] wmem_addr,
  output logic [N-1:0]         load_weight,
  output logic                 amem_rd_en,
  output logic [ROW_W-1:0]     amem_addr,
  output logic                 valid,
  output logic                 res_wr_en,
  output logic [ROW_W-1:0]     res_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int c_wa_w  = $clog2(N);
  localparam int c_cnt_w = cnt_width(ROW_W, PIPE_LAT, N);

  localparam logic [c_cnt_w-1:0] c_n    = c_cnt_w'(N);
  localparam logic [c_cnt_w-1:0] c_pipe = c_cnt_w'(PIPE_LAT);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;      // t in LOAD_W, c in RUN
  logic [ROW_W-1:0]     r_m;        // captured row count
  logic [c_cnt_w-1:0]   w_m_ext;
  logic [c_cnt_w-1:0]   w_last_c;
  logic [c_cnt_w-1:0]   w_res_idx;
  logic [N-1:0]         w_lw_onehot;
  logic                 w_load_last;
  logic                 w_run_last;

  assign w_m_ext     = c_cnt_w'(r_m);
  assign w_last_c    = w_m_ext + c_pipe;
  assign w_res_idx   = r_cnt - c_pipe - c_one;
  assign w_load_last = (r_cnt == c_n);
  assign w_run_last  = (r_cnt == w_last_c);
  // Weight for row t-1 arrives one cycle after its read (1-cycle memory).
  assign w_lw_onehot = N'(1) << (r_cnt - c_one);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD_W;
      LOAD_W:  if (!hold && w_load_last) w_next_state = (r_m == '0) ? DONE : RUN;
      RUN:     if (!hold && w_run_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, phase counter and row-count capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && start) r_m <= num_rows;
      // One counter serves both phases: it restarts on every state change
      // and advances only on cycles that are not held.
      if (w_next_state != r_state)
        r_cnt <= '0;
      else if ((r_state == LOAD_W || r_state == RUN) && !hold)
        r_cnt <= r_cnt + c_one;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Addresses derive from the frozen counter, so they stay put
  // while hold masks the strobes.
  // --------------------------------------------------------------------------
  always_comb begin
    wmem_rd_en  = 1'b0;
    wmem_addr   = '0;
    load_weight = '0;
    amem_rd_en  = 1'b0;
    amem_addr   = '0;
    valid       = 1'b0;
    res_wr_en   = 1'b0;
    res_addr    = '0;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    case (r_state)
      LOAD_W: begin
        if (r_cnt < c_n) begin
          wmem_addr  = r_cnt[c_wa_w-1:0];
          wmem_rd_en = !hold;
        end else begin
          wmem_addr = c_wa_w'(N - 1);
        end
        if (r_cnt != '0) load_weight = hold ? '0 : w_lw_onehot;
      end
      RUN: begin
        amem_addr  = (r_cnt < w_m_ext) ? r_cnt[ROW_W-1:0] : (r_m - ROW_W'(1));
        amem_rd_en = !hold && (r_cnt < w_m_ext);
        // valid covers the whole drain, c = 1 .. M+PIPE_LAT
        valid      = !hold && (r_cnt != '0);
        if (r_cnt > c_pipe) begin
          res_addr  = w_res_idx[ROW_W-1:0];
          res_wr_en = !hold;
        end
      end
      default: ;
    endcase
  end

endmodule : systolic_array_controller
`default_nettype wire

// File: tb/tb_systolic_array_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_array_controller
// Purpose : Self-checking bench for systolic_array_controller (N=2, ROW_W=8,
//           PIPE_LAT=4). Per-cycle vector table plus hand sequences for
//           asynchronous reset and the largest row count.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_array_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_rows;
  logic       hold;
  logic       wmem_rd_en;
  logic [0:0] wmem_addr;
  logic [1:0] load_weight;
  logic       amem_rd_en;
  logic [7:0] amem_addr;
  logic       valid;
  logic       res_wr_en;
  logic [7:0] res_addr;
  logic       busy;
  logic       done;

  systolic_array_controller #(
    .N(2), .ROW_W(8), .PIPE_LAT(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .hold(hold),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .load_weight(load_weight),
    .amem_rd_en(amem_rd_en), .amem_addr(amem_addr), .valid(valid),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] all_out;
  assign all_out = {wmem_rd_en, wmem_addr, load_weight, amem_rd_en, amem_addr,
                    valid, res_wr_en, res_addr, busy, done};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit st; int nr; bit hd;
    bit wrd; int wa; int lw; bit ard; int aa; bit vl; bit rw; int ra; bit bz; bit dn;
  } vec_t;

  function automatic vec_t v(bit st, int nr, bit hd, bit wrd, int wa, int lw,
                             bit ard, int aa, bit vl, bit rw, int ra, bit bz, bit dn);
    vec_t r;
    r.st = st; r.nr = nr; r.hd = hd; r.wrd = wrd; r.wa = wa; r.lw = lw;
    r.ard = ard; r.aa = aa; r.vl = vl; r.rw = rw; r.ra = ra; r.bz = bz; r.dn = dn;
    return r;
  endfunction

  vec_t tbl[$];

  // Observation results for the free-running sequences
  int ob_first_wrd_k, ob_n_wrd, ob_n_lw, ob_n_ard, ob_n_valid, ob_n_wr;
  int ob_last_ra, ob_last_wr_k, ob_done_k, ob_n_busy, ob_seq_err, ob_overlap;

  // Start was driven in cycle 0; watch cycles 1.. until done (bounded).
  task automatic observe(input int limit);
    ob_first_wrd_k = -1; ob_n_wrd = 0; ob_n_lw = 0; ob_n_ard = 0; ob_n_valid = 0;
    ob_n_wr = 0; ob_last_ra = -1; ob_last_wr_k = -1; ob_done_k = -1; ob_n_busy = 0;
    ob_seq_err = 0; ob_overlap = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (busy) ob_n_busy++;
      if (wmem_rd_en) begin
        if (ob_first_wrd_k < 0) ob_first_wrd_k = k;
        if (int'(wmem_addr) != ob_n_wrd) ob_seq_err++;
        ob_n_wrd++;
      end
      if (load_weight != 2'b00) begin
        if (load_weight != (2'b01 << ob_n_lw)) ob_seq_err++;
        ob_n_lw++;
      end
      if (amem_rd_en) begin
        if (int'(amem_addr) != ob_n_ard) ob_seq_err++;
        ob_n_ard++;
      end
      if (valid) ob_n_valid++;
      if (valid && load_weight != 2'b00) ob_overlap++;
      if (res_wr_en) begin
        if (int'(res_addr) != ob_n_wr) ob_seq_err++;
        ob_n_wr++;
        ob_last_ra   = int'(res_addr);
        ob_last_wr_k = k;
      end
      if (done) begin
        ob_done_k = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; num_rows = 8'd5; hold = 1'b0;
    #2 check("reset outputs zero", 32'(all_out), 32'd0);
    @(posedge clk);
    @(negedge clk) check("reset ignores start", 32'(all_out), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    //               st nr hd  wrd wa lw  ard aa vl rw ra bz dn
    // M=3, no hold
    tbl.push_back(v(1, 3, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 2,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // M=0: weights still load, RUN skipped
    tbl.push_back(v(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 2,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // M=3, start re-pulsed in RUN and in DONE (with hold in DONE): ignored
    tbl.push_back(v(1, 3, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 2,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 9, 0,  0, 0, 0,  1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 2, 1, 0));
    tbl.push_back(v(1, 9, 1,  0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // M=3, hold for 3 cycles from S+6: later strobes slip by 3
    tbl.push_back(v(1, 3, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 2,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      start    = tbl[i].st;
      num_rows = 8'(tbl[i].nr);
      hold     = tbl[i].hd;
      @(negedge clk);
      check($sformatf("v%0d wmem_rd_en", i), 32'(wmem_rd_en), 32'(tbl[i].wrd));
      check($sformatf("v%0d load_weight", i), 32'(load_weight), 32'(tbl[i].lw));
      check($sformatf("v%0d amem_rd_en", i), 32'(amem_rd_en), 32'(tbl[i].ard));
      check($sformatf("v%0d valid", i), 32'(valid), 32'(tbl[i].vl));
      check($sformatf("v%0d res_wr_en", i), 32'(res_wr_en), 32'(tbl[i].rw));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bz));
      check($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].dn));
      if (tbl[i].wrd) check($sformatf("v%0d wmem_addr", i), 32'(wmem_addr), 32'(tbl[i].wa));
      if (tbl[i].ard) check($sformatf("v%0d amem_addr", i), 32'(amem_addr), 32'(tbl[i].aa));
      if (tbl[i].rw)  check($sformatf("v%0d res_addr", i), 32'(res_addr), 32'(tbl[i].ra));
      if (!tbl[i].bz) check($sformatf("v%0d idle outputs", i), 32'(all_out), 32'd0);
    end
    start = 1'b0; hold = 1'b0;

    // Asynchronous reset in the middle of RUN, then a clean restart with M=2
    @(posedge clk);
    #1 start = 1'b1; num_rows = 8'd3;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
    check("pre-reset valid", 32'(valid), 32'd1);
    #1 reset = 1'b1;
    #1 check("async reset outputs", 32'(all_out), 32'd0);
    @(posedge clk);
    @(negedge clk) check("held reset outputs", 32'(all_out), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; num_rows = 8'd2;
    observe(40);
    check("m2 first wmem read cycle", ob_first_wrd_k, 1);
    check("m2 weight reads", ob_n_wrd, 2);
    check("m2 weight loads", ob_n_lw, 2);
    check("m2 act reads", ob_n_ard, 2);
    check("m2 valid cycles", ob_n_valid, 6);
    check("m2 result writes", ob_n_wr, 2);
    check("m2 last res_addr", ob_last_ra, 1);
    check("m2 last write cycle", ob_last_wr_k, 10);
    check("m2 done cycle", ob_done_k, 11);
    check("m2 busy cycles", ob_n_busy, 11);
    check("m2 address order", ob_seq_err, 0);
    check("m2 load/valid overlap", ob_overlap, 0);
    @(posedge clk);
    @(negedge clk) check("m2 back to idle", 32'(all_out), 32'd0);

    // Largest row count: counter must reach 259 without wrapping
    @(posedge clk);
    #1 start = 1'b1; num_rows = 8'd255;
    observe(400);
    check("m255 weight loads", ob_n_lw, 2);
    check("m255 act reads", ob_n_ard, 255);
    check("m255 valid cycles", ob_n_valid, 259);
    check("m255 result writes", ob_n_wr, 255);
    check("m255 last res_addr", ob_last_ra, 254);
    check("m255 last write cycle", ob_last_wr_k, 263);
    check("m255 done cycle", ob_done_k, 264);
    check("m255 busy cycles", ob_n_busy, 264);
    check("m255 address order", ob_seq_err, 0);
    @(posedge clk);
    @(negedge clk) check("m255 back to idle", 32'(all_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_systolic_array_controller
`default_nettype wire
